// File: rtl/bp_cce_pkg.sv
// Shared types for the CCE MSHR file: coherence states, MSHR entry layout and field write-mask indices.
package bp_cce_pkg;

  localparam int unsigned num_mshr_lp         = 4;
  localparam int unsigned num_gpr_lp          = 8;
  localparam int unsigned gpr_width_lp        = 64;
  localparam int unsigned num_flags_lp        = 16;
  localparam int unsigned paddr_width_lp      = 40;
  localparam int unsigned block_width_lp      = 512;
  localparam int unsigned lg_block_bytes_lp   = $clog2(block_width_lp / 8);
  localparam int unsigned lce_id_width_lp     = 8;
  localparam int unsigned lce_assoc_width_lp  = 3;
  localparam int unsigned coh_width_lp        = 3;
  localparam int unsigned msg_size_width_lp   = 3;
  localparam int unsigned num_fields_lp       = 6;

  typedef enum logic [coh_width_lp-1:0] {
    e_COH_I = 3'd0,
    e_COH_S = 3'd1,
    e_COH_E = 3'd2,
    e_COH_F = 3'd3,
    e_COH_M = 3'd4,
    e_COH_O = 3'd5
  } bp_coh_states_e;

  // Bit positions inside field_w_mask_i
  typedef enum int unsigned {
    e_mshr_field_size     = 0,
    e_mshr_field_lce      = 1,
    e_mshr_field_paddr    = 2,
    e_mshr_field_way      = 3,
    e_mshr_field_lru_way  = 4,
    e_mshr_field_next_coh = 5
  } bp_cce_mshr_field_e;

  typedef struct packed {
    logic [lce_id_width_lp-1:0]    lce_id;
    logic [paddr_width_lp-1:0]     paddr;
    logic [lce_assoc_width_lp-1:0] way_id;
    logic [lce_assoc_width_lp-1:0] lru_way_id;
    logic [paddr_width_lp-1:0]     lru_paddr;
    logic [coh_width_lp-1:0]       next_coh_state;
    logic [msg_size_width_lp-1:0]  msg_size;
    logic [num_flags_lp-1:0]       flags;
  } bp_cce_mshr_entry_s;

endpackage

// File: rtl/bp_cce_mshr_entry.sv
// One MSHR entry: valid bit plus payload, with free/alloc/field-write/LRU-writeback update priority.
module bp_cce_mshr_entry
  import bp_cce_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          alloc_i,
  input  logic                          free_i,
  input  logic [coh_width_lp-1:0]       coh_state_i,
  input  logic                          wr_v_i,
  input  logic [num_fields_lp-1:0]      field_w_mask_i,
  input  logic [num_flags_lp-1:0]       flag_w_mask_i,
  input  logic [paddr_width_lp-1:0]     src_a_i,
  input  logic                          lru_v_i,
  input  logic [paddr_width_lp-1:0]     lru_paddr_i,
  output logic                          valid_o,
  output bp_cce_mshr_entry_s            entry_o
);

  logic               valid_q, valid_d;
  bp_cce_mshr_entry_s entry_q, entry_d;

  // Free beats alloc-clear beats field writes; writes only land on live entries
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (free_i && valid_q) begin
      valid_d = 1'b0;
    end else if (alloc_i) begin
      valid_d                = 1'b1;
      entry_d                = '0;
      entry_d.next_coh_state = coh_state_i;
    end else if (valid_q) begin
      if (wr_v_i) begin
        if (field_w_mask_i[e_mshr_field_size])
          entry_d.msg_size = src_a_i[msg_size_width_lp-1:0];
        if (field_w_mask_i[e_mshr_field_lce])
          entry_d.lce_id = src_a_i[lce_id_width_lp-1:0];
        if (field_w_mask_i[e_mshr_field_paddr])
          entry_d.paddr = src_a_i;
        if (field_w_mask_i[e_mshr_field_way])
          entry_d.way_id = src_a_i[lce_assoc_width_lp-1:0];
        if (field_w_mask_i[e_mshr_field_lru_way])
          entry_d.lru_way_id = src_a_i[lce_assoc_width_lp-1:0];
        if (field_w_mask_i[e_mshr_field_next_coh])
          entry_d.next_coh_state = src_a_i[coh_width_lp-1:0];
        for (int f = 0; f < int'(num_flags_lp); f++) begin
          if (flag_w_mask_i[f]) entry_d.flags[f] = src_a_i[0];
        end
      end
      if (lru_v_i) entry_d.lru_paddr = lru_paddr_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/bp_cce_mshr_file.sv
// CCE register block: num_mshr_p MSHRs with free list and block conflict lookup, GPR file, default coh state.
module bp_cce_mshr_file
  import bp_cce_pkg::*;
#(
  parameter int unsigned num_mshr_p        = num_mshr_lp,
  parameter int unsigned num_gpr_p         = num_gpr_lp,
  parameter int unsigned gpr_width_p       = gpr_width_lp,
  parameter int unsigned num_flags_p       = num_flags_lp,
  parameter int unsigned paddr_width_p     = paddr_width_lp,
  parameter int unsigned block_width_p     = block_width_lp,
  parameter int unsigned lce_id_width_p    = lce_id_width_lp,
  parameter int unsigned lce_assoc_width_p = lce_assoc_width_lp,
  parameter int unsigned coh_width_p       = coh_width_lp,
  localparam int unsigned idw_lp           = $clog2(num_mshr_p),
  localparam int unsigned gpr_idw_lp       = $clog2(num_gpr_p),
  localparam int unsigned lg_block_bytes_p = $clog2(block_width_p / 8)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   stall_i,
  output logic                                   alloc_v_o,
  output logic [idw_lp-1:0]                      alloc_id_o,
  input  logic                                   alloc_yumi_i,
  input  logic                                   free_v_i,
  input  logic [idw_lp-1:0]                      free_id_i,
  input  logic [idw_lp-1:0]                      sel_id_i,
  input  logic [num_fields_lp-1:0]               field_w_mask_i,
  input  logic [num_flags_p-1:0]                 flag_w_mask_i,
  input  logic [gpr_width_p-1:0]                 src_a_i,
  input  logic                                   dir_lru_v_i,
  input  logic [paddr_width_p-1:0]               dir_lru_paddr_i,
  input  logic [num_gpr_p-1:0]                   gpr_w_mask_i,
  input  logic [gpr_width_p-1:0]                 alu_res_i,
  input  logic                                   gpr_src_a_v_i,
  input  logic                                   dir_addr_v_i,
  input  logic [paddr_width_p-1:0]               dir_addr_i,
  input  logic [gpr_idw_lp-1:0]                  dir_addr_gpr_i,
  input  logic                                   coh_w_v_i,
  input  logic [paddr_width_p-1:0]               match_paddr_i,
  output logic                                   match_v_o,
  output logic [idw_lp-1:0]                      match_id_o,
  output logic [num_mshr_p-1:0]                  valid_o,
  output bp_cce_mshr_entry_s [num_mshr_p-1:0]    mshr_o,
  output logic [num_gpr_p-1:0][gpr_width_p-1:0]  gpr_o,
  output logic [coh_width_p-1:0]                 coh_state_o
);

  logic [num_mshr_p-1:0] valid;
  logic [num_mshr_p-1:0] alloc_sel, free_sel, wr_sel, lru_sel;

  logic [num_gpr_p-1:0][gpr_width_p-1:0] gpr_q, gpr_d;
  logic [coh_width_p-1:0]                coh_state_q, coh_state_d;
  logic [num_gpr_p-1:0]                  gpr_mask;
  logic [gpr_width_p-1:0]                gpr_wdata;

  // Offset bits never take part in the block match
  logic unused_match_offset;
  assign unused_match_offset = ^match_paddr_i[lg_block_bytes_p-1:0];

  // Free list: lowest-index invalid entry
  always_comb begin
    alloc_v_o  = 1'b0;
    alloc_id_o = '0;
    for (int i = int'(num_mshr_p) - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        alloc_v_o  = 1'b1;
        alloc_id_o = idw_lp'(i);
      end
    end
  end

  always_comb begin
    alloc_sel = '0;
    free_sel  = '0;
    wr_sel    = '0;
    lru_sel   = '0;
    for (int i = 0; i < int'(num_mshr_p); i++) begin
      alloc_sel[i] = alloc_yumi_i & alloc_v_o & (alloc_id_o == idw_lp'(i));
      free_sel[i]  = free_v_i & (free_id_i == idw_lp'(i));
      wr_sel[i]    = ~stall_i & (sel_id_i == idw_lp'(i));
      lru_sel[i]   = dir_lru_v_i & (sel_id_i == idw_lp'(i));
    end
  end

  for (genvar g = 0; g < num_mshr_p; g++) begin : g_entry
    bp_cce_mshr_entry u_entry (
      .clk_i          (clk_i),
      .reset_n_i      (reset_n_i),
      .alloc_i        (alloc_sel[g]),
      .free_i         (free_sel[g]),
      .coh_state_i    (coh_state_q),
      .wr_v_i         (wr_sel[g]),
      .field_w_mask_i (field_w_mask_i),
      .flag_w_mask_i  (flag_w_mask_i),
      .src_a_i        (src_a_i[paddr_width_p-1:0]),
      .lru_v_i        (lru_sel[g]),
      .lru_paddr_i    (dir_lru_paddr_i),
      .valid_o        (valid[g]),
      .entry_o        (mshr_o[g])
    );
  end

  // Block conflict lookup against registered state only
  always_comb begin
    match_v_o  = 1'b0;
    match_id_o = '0;
    for (int i = int'(num_mshr_p) - 1; i >= 0; i--) begin
      if (valid[i] && (mshr_o[i].paddr[paddr_width_p-1:lg_block_bytes_p]
                       == match_paddr_i[paddr_width_p-1:lg_block_bytes_p])) begin
        match_v_o  = 1'b1;
        match_id_o = idw_lp'(i);
      end
    end
  end

  // Directory RDE write is exempt from stall and overrides the data source
  always_comb begin
    gpr_d    = gpr_q;
    gpr_mask = stall_i ? '0 : gpr_w_mask_i;
    if (dir_addr_v_i) gpr_mask[dir_addr_gpr_i] = 1'b1;
    if (dir_addr_v_i)       gpr_wdata = gpr_width_p'(dir_addr_i);
    else if (gpr_src_a_v_i) gpr_wdata = src_a_i;
    else                    gpr_wdata = alu_res_i;
    for (int i = 0; i < int'(num_gpr_p); i++) begin
      if (gpr_mask[i]) gpr_d[i] = gpr_wdata;
    end
  end

  always_comb begin
    coh_state_d = coh_state_q;
    if (coh_w_v_i && !stall_i) coh_state_d = src_a_i[coh_width_p-1:0];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      gpr_q       <= '0;
      coh_state_q <= e_COH_I;
    end else begin
      gpr_q       <= gpr_d;
      coh_state_q <= coh_state_d;
    end
  end

  assign valid_o     = valid;
  assign gpr_o       = gpr_q;
  assign coh_state_o = coh_state_q;

  a_alloc_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                  alloc_yumi_i |-> alloc_v_o);

endmodule
